// File: rtl/ps2_kbmat.sv
// PS/2 set-2 keyboard receiver that maintains a 64-key matrix for the Blink keyboard port.
// Line filtering, 11-bit framing with timeout, prefix decode, and a registered map-ROM lookup.
module ps2_kbmat #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 19660
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [8:0]  map_addr,
  input  logic [6:0]  map_data,
  input  logic        kb_clr,
  output logic [63:0] kbmat,
  output logic        kb_evt,
  output logic [7:0]  rx_data,
  output logic        rx_vld,
  output logic        frame_err
);

  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_APPLY
  } state_t;

  // ---------------------------------------------------------------
  // Input path: index 0 = ps2_clk, index 1 = ps2_dat
  // ---------------------------------------------------------------
  logic [1:0] line_in;
  logic [1:0] line_filt;

  assign line_in = {ps2_dat, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic              sync1_reg;
      logic              sync2_reg;
      logic              filt_reg;
      logic [FCNT_W-1:0] cnt_reg;

      // Filtered level only moves after FILT_LEN consecutive disagreeing samples.
      always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= line_in[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FCNT_W'(FILT_LEN - 1)) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign line_filt[gi] = filt_reg;
    end
  endgenerate

  logic clk_f;
  logic dat_f;
  logic clk_f_d_reg;
  logic fall;

  assign clk_f = line_filt[0];
  assign dat_f = line_filt[1];
  assign fall  = clk_f_d_reg & ~clk_f;

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) clk_f_d_reg <= 1'b1;
    else        clk_f_d_reg <= clk_f;
  end

  // ---------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------
  logic [3:0]       bit_cnt_reg;
  logic [9:0]       shift_reg;
  logic [TMR_W-1:0] tmr_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_vld_reg;
  logic             frame_ok;
  logic             last_bit;
  logic             timeout;
  logic             rx_err;

  // shift_reg holds {parity, d7..d0, start}; stop bit is the live sample.
  always_comb begin
    frame_ok = ~shift_reg[0] & (^shift_reg[9:1]) & dat_f;
    last_bit = fall && (bit_cnt_reg == 4'd10);
    timeout  = !fall && (bit_cnt_reg != 4'd0) && (tmr_reg == TMR_W'(TIMEOUT_CYC - 1));
    rx_err   = (last_bit && !frame_ok) || timeout;
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tmr_reg     <= '0;
      rx_data_reg <= '0;
      rx_vld_reg  <= 1'b0;
    end else begin
      rx_vld_reg <= 1'b0;
      if (fall) begin
        tmr_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= '0;
          if (frame_ok) begin
            rx_data_reg <= shift_reg[8:1];
            rx_vld_reg  <= 1'b1;
          end
        end else begin
          shift_reg[bit_cnt_reg] <= dat_f;
          bit_cnt_reg            <= bit_cnt_reg + 4'd1;
        end
      end else if (bit_cnt_reg != 4'd0) begin
        if (timeout) begin
          bit_cnt_reg <= '0;
          tmr_reg     <= '0;
        end else begin
          tmr_reg <= tmr_reg + 1'b1;
        end
      end else begin
        tmr_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Decoder FSM and key matrix
  // ---------------------------------------------------------------
  state_t      state_reg, state_next;
  logic        ext_reg, ext_next;
  logic        brk_reg, brk_next;
  logic [2:0]  skip_reg, skip_next;
  logic [8:0]  map_addr_reg, map_addr_next;
  logic [63:0] kbmat_reg, kbmat_next;
  logic        kb_evt_reg, kb_evt_next;
  logic        frame_err_reg, frame_err_next;
  logic        overrun;

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state_reg     <= ST_IDLE;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      skip_reg      <= '0;
      map_addr_reg  <= '0;
      kbmat_reg     <= '0;
      kb_evt_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      skip_reg      <= skip_next;
      map_addr_reg  <= map_addr_next;
      kbmat_reg     <= kbmat_next;
      kb_evt_reg    <= kb_evt_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ext_next      = ext_reg;
    brk_next      = brk_reg;
    skip_next     = skip_reg;
    map_addr_next = map_addr_reg;
    kbmat_next    = kbmat_reg;
    overrun       = rx_vld_reg && (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        if (rx_vld_reg) begin
          if (skip_reg != 3'd0) begin
            skip_next = skip_reg - 3'd1;
          end else begin
            case (rx_data_reg)
              8'hE0: ext_next = 1'b1;
              8'hF0: brk_next = 1'b1;
              8'hE1: begin
                skip_next = 3'd7;
                ext_next  = 1'b0;
                brk_next  = 1'b0;
              end
              8'hAA: begin
                kbmat_next = '0;
                ext_next   = 1'b0;
                brk_next   = 1'b0;
              end
              8'h00, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                ext_next = 1'b0;
                brk_next = 1'b0;
              end
              default: begin
                map_addr_next = {ext_reg, rx_data_reg};
                state_next    = ST_LOOKUP;
              end
            endcase
          end
        end
      end
      ST_LOOKUP: state_next = ST_APPLY;
      ST_APPLY: begin
        if (map_data[6]) kbmat_next[map_data[5:0]] = ~brk_reg;
        ext_next   = 1'b0;
        brk_next   = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Host clear overrides anything the decoder did this cycle.
    if (kb_clr) begin
      kbmat_next = '0;
      ext_next   = 1'b0;
      brk_next   = 1'b0;
      skip_next  = '0;
    end

    kb_evt_next    = (kbmat_next != kbmat_reg);
    frame_err_next = rx_err || overrun;
  end

  assign map_addr  = map_addr_reg;
  assign kbmat     = kbmat_reg;
  assign kb_evt    = kb_evt_reg;
  assign rx_data   = rx_data_reg;
  assign rx_vld    = rx_vld_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_kbmat.sv
// Directed bench for ps2_kbmat: frames are bit-banged on ps2_clk/ps2_dat, a registered map ROM is modelled.
module tb_ps2_kbmat;
  localparam int HALF        = 8;
  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 19660;
  localparam logic [63:0] B0  = 64'h1;
  localparam logic [63:0] B7  = 64'h1 << 7;
  localparam logic [63:0] B20 = 64'h1 << 20;
  localparam logic [63:0] B42 = 64'h1 << 42;
  localparam logic [63:0] B63 = 64'h1 << 63;

  logic        mck = 1'b0;
  logic        rin_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        kb_clr = 1'b0;
  logic [8:0]  map_addr;
  logic [6:0]  map_data;
  logic [63:0] kbmat;
  logic        kb_evt;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        frame_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 mck = ~mck;

  ps2_kbmat #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .mck(mck), .rin_n(rin_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .map_addr(map_addr), .map_data(map_data), .kb_clr(kb_clr),
    .kbmat(kbmat), .kb_evt(kb_evt), .rx_data(rx_data), .rx_vld(rx_vld),
    .frame_err(frame_err)
  );

  function automatic logic [6:0] rom_f(input logic [8:0] a);
    case (a)
      9'h01C:  return 7'h6A; // bit 42
      9'h075:  return 7'h40; // bit 0
      9'h175:  return 7'h47; // bit 7
      9'h01B:  return 7'h54; // bit 20
      9'h023:  return 7'h7F; // bit 63
      default: return 7'h00;
    endcase
  endfunction

  always @(posedge mck) map_data <= rom_f(map_addr);

  // Event monitor: counts pulses and remembers when they happened.
  int         cyc = 0;
  int         n_vld = 0, n_err = 0, n_evt = 0, vld_cyc = 0, evt_cyc = 0;
  logic [7:0] last_rx = 8'h00;

  always @(posedge mck) cyc <= cyc + 1;

  always @(negedge mck) begin
    if (rx_vld) begin
      n_vld   <= n_vld + 1;
      vld_cyc <= cyc;
      last_rx <= rx_data;
    end
    if (frame_err) n_err <= n_err + 1;
    if (kb_evt) begin
      n_evt   <= n_evt + 1;
      evt_cyc <= cyc;
    end
  end

  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(negedge mck);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge mck);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~(^d)) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge mck);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge mck);
    n_total++; if (kbmat !== 64'h0) $display("FAIL reset_kbmat: got %h want 0", kbmat); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
    n_total++; if (map_addr !== 9'h000) $display("FAIL reset_map_addr: got %h want 000", map_addr); else n_pass++;
    n_total++; if ({kb_evt, rx_vld, frame_err} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {kb_evt, rx_vld, frame_err}); else n_pass++;
    rin_n = 1'b1;
    repeat (4) @(negedge mck);
  endtask

  task automatic test_make;
    int v0, e0, k0;
    v0 = n_vld; e0 = n_err; k0 = n_evt;
    send_frame(8'h1C, 1'b0);
    n_total++; if (n_vld - v0 !== 1) $display("FAIL make_vld_count: got %0d want 1", n_vld - v0); else n_pass++;
    n_total++; if (last_rx !== 8'h1C) $display("FAIL make_rx_data: got %h want 1c", last_rx); else n_pass++;
    n_total++; if (kbmat !== B42) $display("FAIL make_kbmat: got %h want %h", kbmat, B42); else n_pass++;
    n_total++; if (n_evt - k0 !== 1) $display("FAIL make_evt_count: got %0d want 1", n_evt - k0); else n_pass++;
    n_total++; if (evt_cyc - vld_cyc !== 3) $display("FAIL make_latency: got %0d want 3", evt_cyc - vld_cyc); else n_pass++;
    n_total++; if (n_err - e0 !== 0) $display("FAIL make_err: got %0d want 0", n_err - e0); else n_pass++;
  endtask

  task automatic test_break;
    int k0;
    k0 = n_evt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    n_total++; if (kbmat !== 64'h0) $display("FAIL break_kbmat: got %h want 0", kbmat); else n_pass++;
    n_total++; if (n_evt - k0 !== 1) $display("FAIL break_evt: got %0d want 1", n_evt - k0); else n_pass++;
    k0 = n_evt;
    send_frame(8'h1C, 1'b0);
    n_total++; if (kbmat !== B42) $display("FAIL remake_kbmat: got %h want %h", kbmat, B42); else n_pass++;
    n_total++; if (n_evt - k0 !== 1) $display("FAIL remake_evt: got %0d want 1", n_evt - k0); else n_pass++;
    k0 = n_evt;
    send_frame(8'h1C, 1'b0);
    n_total++; if (n_evt - k0 !== 0) $display("FAIL repeat_evt: got %0d want 0", n_evt - k0); else n_pass++;
    n_total++; if (kbmat !== B42) $display("FAIL repeat_kbmat: got %h want %h", kbmat, B42); else n_pass++;
  endtask

  task automatic test_extended;
    int k0;
    k0 = n_evt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    n_total++; if (kbmat !== (B42 | B7)) $display("FAIL ext_kbmat: got %h want %h", kbmat, B42 | B7); else n_pass++;
    n_total++; if (kbmat[0] !== 1'b0) $display("FAIL ext_bit0: got %b want 0", kbmat[0]); else n_pass++;
    n_total++; if (n_evt - k0 !== 1) $display("FAIL ext_evt: got %0d want 1", n_evt - k0); else n_pass++;
  endtask

  task automatic test_parity;
    int v0, e0;
    v0 = n_vld; e0 = n_err;
    send_frame(8'h1C, 1'b1);
    n_total++; if (n_err - e0 !== 1) $display("FAIL parity_err: got %0d want 1", n_err - e0); else n_pass++;
    n_total++; if (n_vld - v0 !== 0) $display("FAIL parity_vld: got %0d want 0", n_vld - v0); else n_pass++;
    n_total++; if (kbmat !== (B42 | B7)) $display("FAIL parity_kbmat: got %h want %h", kbmat, B42 | B7); else n_pass++;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    n_total++; if (kbmat !== B7) $display("FAIL parity_recover: got %h want %h", kbmat, B7); else n_pass++;
  endtask

  task automatic test_prefix;
    int k0, e0;
    k0 = n_evt;
    send_frame(8'hAA, 1'b0);
    n_total++; if (kbmat !== 64'h0) $display("FAIL aa_kbmat: got %h want 0", kbmat); else n_pass++;
    n_total++; if (n_evt - k0 !== 1) $display("FAIL aa_evt: got %0d want 1", n_evt - k0); else n_pass++;
    send_frame(8'hF0, 1'b0);
    send_frame(8'hFA, 1'b0);
    send_frame(8'h1C, 1'b0);
    n_total++; if (kbmat !== B42) $display("FAIL fa_clears_brk: got %h want %h", kbmat, B42); else n_pass++;
    // Seven bytes after E1 are swallowed; the last of them is an F0.
    e0 = n_err;
    send_frame(8'hE1, 1'b0);
    for (int i = 0; i < 6; i++) send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    n_total++; if (kbmat !== B42) $display("FAIL e1_skip: got %h want %h", kbmat, B42); else n_pass++;
    n_total++; if (n_err - e0 !== 0) $display("FAIL e1_err: got %0d want 0", n_err - e0); else n_pass++;
  endtask

  task automatic test_timeout;
    int e0, got;
    logic [4:0] bits;
    bits = 5'b0_1010;
    got = -1;
    e0 = n_err;
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    ps2_dat = bits[4];
    repeat (HALF) @(negedge mck);
    ps2_clk = 1'b0;
    for (int n = 1; n <= TIMEOUT_CYC + 100; n++) begin
      @(negedge mck);
      if (n == HALF) ps2_clk = 1'b1;
      if (frame_err) begin
        got = n;
        break;
      end
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    // 2 sync + FILT_LEN filter + 1 edge-detect cycles before the timer starts.
    n_total++; if (got !== TIMEOUT_CYC + 7) $display("FAIL timeout_delay: got %0d want %0d", got, TIMEOUT_CYC + 7); else n_pass++;
    repeat (20) @(negedge mck);
    n_total++; if (n_err - e0 !== 1) $display("FAIL timeout_err_count: got %0d want 1", n_err - e0); else n_pass++;
    send_frame(8'h1B, 1'b0);
    n_total++; if (last_rx !== 8'h1B) $display("FAIL timeout_next_rx: got %h want 1b", last_rx); else n_pass++;
    n_total++; if (kbmat !== (B42 | B20)) $display("FAIL timeout_next_kbmat: got %h want %h", kbmat, B42 | B20); else n_pass++;
  endtask

  task automatic test_glitch;
    int e0;
    e0 = n_err;
    ps2_clk = 1'b0;
    repeat (FILT_LEN - 1) @(negedge mck);
    ps2_clk = 1'b1;
    repeat (20) @(negedge mck);
    send_frame(8'h23, 1'b0);
    n_total++; if (n_err - e0 !== 0) $display("FAIL glitch_err: got %0d want 0", n_err - e0); else n_pass++;
    n_total++; if (last_rx !== 8'h23) $display("FAIL glitch_rx: got %h want 23", last_rx); else n_pass++;
    n_total++; if (kbmat !== (B42 | B20 | B63)) $display("FAIL glitch_kbmat: got %h want %h", kbmat, B42 | B20 | B63); else n_pass++;
  endtask

  task automatic test_kb_clr;
    int  k0;
    bit  seen;
    seen = 1'b0;
    k0 = n_evt;
    fork
      send_frame(8'h75, 1'b0);
      begin
        for (int i = 0; i < 600; i++) begin
          @(negedge mck);
          if (rx_vld) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          @(negedge mck);
          @(negedge mck);
          kb_clr = 1'b1;
          @(negedge mck);
          kb_clr = 1'b0;
        end
      end
    join
    n_total++; if (seen !== 1'b1) $display("FAIL clr_wait_vld: got %b want 1", seen); else n_pass++;
    n_total++; if (kbmat !== 64'h0) $display("FAIL clr_kbmat: got %h want 0", kbmat); else n_pass++;
    n_total++; if (n_evt - k0 !== 1) $display("FAIL clr_evt: got %0d want 1", n_evt - k0); else n_pass++;
    send_frame(8'h75, 1'b0);
    n_total++; if (kbmat !== B0) $display("FAIL clr_after_make: got %h want %h", kbmat, B0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int e0, v0;
    send_frame(8'h1C, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rin_n = 1'b0;
    repeat (2) @(negedge mck);
    n_total++; if (kbmat !== 64'h0) $display("FAIL rst_mid_kbmat: got %h want 0", kbmat); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); else n_pass++;
    n_total++; if (map_addr !== 9'h000) $display("FAIL rst_mid_map_addr: got %h want 000", map_addr); else n_pass++;
    ps2_dat = 1'b1;
    rin_n = 1'b1;
    repeat (20) @(negedge mck);
    e0 = n_err; v0 = n_vld;
    send_frame(8'h1B, 1'b0);
    n_total++; if (n_err - e0 !== 0) $display("FAIL rst_mid_err: got %0d want 0", n_err - e0); else n_pass++;
    n_total++; if (n_vld - v0 !== 1) $display("FAIL rst_mid_vld: got %0d want 1", n_vld - v0); else n_pass++;
    n_total++; if (kbmat !== B20) $display("FAIL rst_mid_kbmat_after: got %h want %h", kbmat, B20); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_make;
    test_break;
    test_extended;
    test_parity;
    test_prefix;
    test_timeout;
    test_glitch;
    test_kb_clr;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
